// File: rtl/intra16x16_mb_sequencer.sv
// intra16x16_mb_sequencer
// Frame-level controller for the Intra 16x16 luma path. Walks macroblocks in
// raster order, launches the prediction/SAD engine for each one, fires the
// 16x16 saver once the engine is done and the residue sink can take a new MB,
// then captures the mode the saver selected.
//
// Handshakes: pred_start_o is a one-cycle launch; pred_done_i is only looked
// at while waiting for the engine. A save happens on the first cycle where
// pred_done_i has been seen and sink_ready_i is high; sink_ready_i is the
// ready of the residue consumer and may stall indefinitely.
module intra16x16_mb_sequencer #(
    parameter int MB_COLS = 16,
    parameter int MB_ROWS = 16,
    parameter int TIMEOUT = 1023
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       frame_start_i,
    input  logic       pred_done_i,
    input  logic       sink_ready_i,
    input  logic [2:0] mode_i,
    output logic       pred_start_o,
    output logic       save_enable_o,
    output logic [8:0] mbnumber_o,
    output logic       top_avail_o,
    output logic       left_avail_o,
    output logic [2:0] last_mode_o,
    output logic       mode_valid_o,
    output logic       busy_o,
    output logic       frame_done_o,
    output logic       error_o,
    output logic [2:0] state_o
);

    localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [TW-1:0] TO_MAX   = TW'(TIMEOUT);
    localparam logic [8:0]    COL_LAST = 9'(MB_COLS - 1);
    localparam logic [8:0]    MB_LAST  = 9'(MB_COLS * MB_ROWS - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_LAUNCH    = 3'd1,
        S_WAIT_PRED = 3'd2,
        S_HOLD      = 3'd3,
        S_SAVE      = 3'd4,
        S_CAPTURE   = 3'd5,
        S_DONE      = 3'd6
    } state_t;

    state_t         state_q;
    logic [8:0]     col_q, row_q, mb_q;
    logic [8:0]     col_d, row_d, mb_d;
    logic [TW-1:0]  tcnt_q;
    logic           pred_start_q, save_enable_q, mode_valid_q;
    logic           frame_done_q, error_q;
    logic [2:0]     last_mode_q;
    logic           col_wrap, mb_last;

    // Raster advance: next column, wrapping into the next row at the right edge.
    always_comb begin
        col_wrap = (col_q == COL_LAST);
        mb_last  = (mb_q == MB_LAST);
        col_d    = col_wrap ? 9'd0 : col_q + 9'd1;
        row_d    = col_wrap ? row_q + 9'd1 : row_q;
        mb_d     = mb_q + 9'd1;
    end

    // Sequencer FSM; every pulse output is registered on entry to its state.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q       <= S_IDLE;
            col_q         <= 9'd0;
            row_q         <= 9'd0;
            mb_q          <= 9'd0;
            tcnt_q        <= '0;
            pred_start_q  <= 1'b0;
            save_enable_q <= 1'b0;
            mode_valid_q  <= 1'b0;
            frame_done_q  <= 1'b0;
            error_q       <= 1'b0;
            last_mode_q   <= 3'd0;
        end else begin
            pred_start_q  <= 1'b0;
            save_enable_q <= 1'b0;
            mode_valid_q  <= 1'b0;
            frame_done_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (frame_start_i) begin
                        col_q        <= 9'd0;
                        row_q        <= 9'd0;
                        mb_q         <= 9'd0;
                        error_q      <= 1'b0;
                        pred_start_q <= 1'b1;
                        state_q      <= S_LAUNCH;
                    end
                end
                S_LAUNCH: begin
                    tcnt_q  <= '0;
                    state_q <= S_WAIT_PRED;
                end
                S_WAIT_PRED: begin
                    if (pred_done_i) begin
                        if (sink_ready_i) begin
                            save_enable_q <= 1'b1;
                            state_q       <= S_SAVE;
                        end else begin
                            state_q <= S_HOLD;
                        end
                    end else if (tcnt_q == TO_MAX) begin
                        // Engine never answered: abandon the frame silently.
                        error_q <= 1'b1;
                        state_q <= S_IDLE;
                    end else begin
                        tcnt_q <= tcnt_q + 1'b1;
                    end
                end
                S_HOLD: begin
                    if (sink_ready_i) begin
                        save_enable_q <= 1'b1;
                        state_q       <= S_SAVE;
                    end
                end
                S_SAVE: begin
                    state_q <= S_CAPTURE;
                end
                S_CAPTURE: begin
                    last_mode_q  <= mode_i;
                    mode_valid_q <= 1'b1;
                    col_q        <= col_d;
                    row_q        <= row_d;
                    mb_q         <= mb_d;
                    if (mb_last) begin
                        state_q <= S_DONE;
                    end else begin
                        pred_start_q <= 1'b1;
                        state_q      <= S_LAUNCH;
                    end
                end
                S_DONE: begin
                    frame_done_q <= 1'b1;
                    state_q      <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign pred_start_o  = pred_start_q;
    assign save_enable_o = save_enable_q;
    assign mbnumber_o    = mb_q;
    assign top_avail_o   = (row_q != 9'd0);
    assign left_avail_o  = (col_q != 9'd0);
    assign last_mode_o   = last_mode_q;
    assign mode_valid_o  = mode_valid_q;
    assign busy_o        = (state_q != S_IDLE);
    assign frame_done_o  = frame_done_q;
    assign error_o       = error_q;
    assign state_o       = state_q;

endmodule

// File: tb/tb_intra16x16_mb_sequencer.sv
// Bench for intra16x16_mb_sequencer: drives the engine/saver/sink side of the
// sequencer and checks every MB against a per-MB timeline model.
module tb_intra16x16_mb_sequencer;

    localparam int MB_COLS  = 16;
    localparam int MB_ROWS  = 16;
    localparam int TIMEOUT  = 15;
    localparam int MB_TOTAL = MB_COLS * MB_ROWS;

    // ---------------- clock / reset ----------------
    logic       clk_i = 1'b0;
    logic       reset_i;
    logic       frame_start_i;
    logic       pred_done_i;
    logic       sink_ready_i;
    logic [2:0] mode_i;
    logic       pred_start_o;
    logic       save_enable_o;
    logic [8:0] mbnumber_o;
    logic       top_avail_o;
    logic       left_avail_o;
    logic [2:0] last_mode_o;
    logic       mode_valid_o;
    logic       busy_o;
    logic       frame_done_o;
    logic       error_o;
    logic [2:0] state_o;

    always #5 clk_i = ~clk_i;

    intra16x16_mb_sequencer #(
        .MB_COLS(MB_COLS),
        .MB_ROWS(MB_ROWS),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk_i(clk_i),
        .reset_i(reset_i),
        .frame_start_i(frame_start_i),
        .pred_done_i(pred_done_i),
        .sink_ready_i(sink_ready_i),
        .mode_i(mode_i),
        .pred_start_o(pred_start_o),
        .save_enable_o(save_enable_o),
        .mbnumber_o(mbnumber_o),
        .top_avail_o(top_avail_o),
        .left_avail_o(left_avail_o),
        .last_mode_o(last_mode_o),
        .mode_valid_o(mode_valid_o),
        .busy_o(busy_o),
        .frame_done_o(frame_done_o),
        .error_o(error_o),
        .state_o(state_o)
    );

    // ---------------- scoreboard state ----------------
    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int fs_cyc = 0;
    int done_cyc = 0;
    int ps_cnt = 0;
    int se_cnt = 0;
    logic [8:0] exp_q[$];

    always @(posedge clk_i) begin
        if (pred_start_o === 1'b1) ps_cnt++;
        if (save_enable_o === 1'b1) se_cnt++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(negedge clk_i);
        cyc++;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_pred_start"}, 32'(pred_start_o), 0);
        chk({tag, "_save_enable"}, 32'(save_enable_o), 0);
        chk({tag, "_mbnumber"}, 32'(mbnumber_o), 0);
        chk({tag, "_top_avail"}, 32'(top_avail_o), 0);
        chk({tag, "_left_avail"}, 32'(left_avail_o), 0);
        chk({tag, "_last_mode"}, 32'(last_mode_o), 0);
        chk({tag, "_mode_valid"}, 32'(mode_valid_o), 0);
        chk({tag, "_busy"}, 32'(busy_o), 0);
        chk({tag, "_frame_done"}, 32'(frame_done_o), 0);
        chk({tag, "_error"}, 32'(error_o), 0);
    endtask

    // Called in IDLE at a negedge; returns at the negedge inside LAUNCH of MB 0.
    task automatic start_frame();
        exp_q.delete();
        for (int i = 0; i < MB_TOTAL; i++) exp_q.push_back(9'(i));
        ps_cnt = 0;
        se_cnt = 0;
        frame_start_i = 1'b1;
        pred_done_i   = 1'b0;
        sink_ready_i  = 1'b0;
        fs_cyc = cyc;
        tick();
        frame_start_i = 1'b0;
        chk("busy_rise", 32'(busy_o), 1);
        chk("error_clear", 32'(error_o), 0);
        chk("mode_valid_first", 32'(mode_valid_o), 0);
    endtask

    // One MB starting at its LAUNCH negedge. WAIT lasts pd_delay+1 cycles with
    // pred_done in the last one, then `hold` cycles of sink_ready low, then
    // SAVE and CAPTURE. Returns at the negedge of the cycle after CAPTURE.
    task automatic do_mb(input int pd_delay, input int hold, input logic [2:0] mval);
        logic [8:0] mb;
        bit last;
        mb   = exp_q.pop_front();
        last = (exp_q.size() == 0);
        chk("launch_pred_start", 32'(pred_start_o), 1);
        chk("launch_mbnumber", 32'(mbnumber_o), 32'(mb));
        chk("top_avail", 32'(top_avail_o), 32'((int'(mb) / MB_COLS) != 0));
        chk("left_avail", 32'(left_avail_o), 32'((int'(mb) % MB_COLS) != 0));
        chk("launch_save_enable", 32'(save_enable_o), 0);
        chk("launch_busy", 32'(busy_o), 1);
        pred_done_i   = 1'($urandom_range(0, 1));
        sink_ready_i  = 1'($urandom_range(0, 1));
        frame_start_i = 1'($urandom_range(0, 1));
        tick();
        for (int k = 0; k <= pd_delay; k++) begin
            chk("wait_pred_start", 32'(pred_start_o), 0);
            chk("wait_save_enable", 32'(save_enable_o), 0);
            chk("wait_mbnumber", 32'(mbnumber_o), 32'(mb));
            chk("wait_mode_valid", 32'(mode_valid_o), 0);
            chk("wait_error", 32'(error_o), 0);
            pred_done_i   = (k == pd_delay);
            sink_ready_i  = (k == pd_delay) ? (hold == 0) : 1'($urandom_range(0, 1));
            frame_start_i = 1'($urandom_range(0, 1));
            tick();
        end
        for (int j = 0; j < hold; j++) begin
            chk("hold_save_enable", 32'(save_enable_o), 0);
            chk("hold_pred_start", 32'(pred_start_o), 0);
            chk("hold_mbnumber", 32'(mbnumber_o), 32'(mb));
            pred_done_i  = 1'($urandom_range(0, 1));
            sink_ready_i = (j == hold - 1);
            tick();
        end
        chk("save_enable", 32'(save_enable_o), 1);
        chk("save_pred_start", 32'(pred_start_o), 0);
        chk("save_mbnumber", 32'(mbnumber_o), 32'(mb));
        frame_start_i = 1'b0;
        pred_done_i   = 1'($urandom_range(0, 1));
        mode_i        = 3'($urandom_range(0, 7));
        tick();
        chk("capture_save_enable", 32'(save_enable_o), 0);
        chk("capture_mode_valid", 32'(mode_valid_o), 0);
        chk("capture_mbnumber", 32'(mbnumber_o), 32'(mb));
        mode_i      = mval;
        pred_done_i = 1'($urandom_range(0, 1));
        tick();
        chk("mode_valid", 32'(mode_valid_o), 1);
        chk("last_mode", 32'(last_mode_o), 32'(mval));
        chk("post_save_enable", 32'(save_enable_o), 0);
        mode_i = 3'($urandom_range(0, 7));
        if (last) begin
            chk("done_pred_start", 32'(pred_start_o), 0);
            chk("done_frame_done_early", 32'(frame_done_o), 0);
            chk("done_busy", 32'(busy_o), 1);
        end
    endtask

    // Called at the DONE negedge.
    task automatic finish_frame();
        frame_start_i = 1'b0;
        pred_done_i   = 1'b0;
        tick();
        chk("frame_done", 32'(frame_done_o), 1);
        chk("busy_fall", 32'(busy_o), 0);
        chk("end_pred_start", 32'(pred_start_o), 0);
        chk("end_mode_valid", 32'(mode_valid_o), 0);
        done_cyc = cyc;
        tick();
        chk("frame_done_pulse", 32'(frame_done_o), 0);
        chk("pred_start_count", 32'(ps_cnt), 32'(MB_TOTAL));
        chk("save_enable_count", 32'(se_cnt), 32'(MB_TOTAL));
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        reset_i       = 1'b1;
        frame_start_i = 1'b0;
        pred_done_i   = 1'b0;
        sink_ready_i  = 1'b0;
        mode_i        = 3'd0;
        tick();
        tick();
        chk_reset("rst");
        reset_i = 1'b0;
        tick();
        chk_reset("idle");

        // Full frame, engine and sink always ready.
        start_frame();
        for (int i = 0; i < MB_TOTAL; i++) do_mb(0, 0, 3'($urandom_range(0, 7)));
        finish_frame();
        chk("frame_latency", 32'(done_cyc - fs_cyc - 1), 32'(1 + MB_TOTAL * 4));

        // Randomised frame: MB 3 reports mode 2, MB 7 sees 7 cycles of backpressure.
        start_frame();
        for (int i = 0; i < MB_TOTAL; i++) begin
            int pd, hd;
            logic [2:0] mv;
            pd = $urandom_range(0, 6);
            hd = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
            mv = 3'($urandom_range(0, 7));
            if (i == 3) mv = 3'd2;
            if (i == 7) hd = 7;
            do_mb(pd, hd, mv);
        end
        finish_frame();

        // Engine never answers: abort after TIMEOUT+1 waiting cycles.
        start_frame();
        chk("to_pred_start", 32'(pred_start_o), 1);
        chk("to_mbnumber", 32'(mbnumber_o), 0);
        pred_done_i  = 1'b0;
        sink_ready_i = 1'b1;
        tick();
        for (int k = 0; k <= TIMEOUT; k++) begin
            chk("to_wait_busy", 32'(busy_o), 1);
            chk("to_wait_error", 32'(error_o), 0);
            pred_done_i = 1'b0;
            tick();
        end
        chk("to_busy", 32'(busy_o), 0);
        chk("to_error", 32'(error_o), 1);
        chk("to_no_frame_done", 32'(frame_done_o), 0);
        for (int k = 0; k < 3; k++) begin
            pred_done_i = 1'b1;
            tick();
            chk("to_idle_busy", 32'(busy_o), 0);
            chk("to_idle_frame_done", 32'(frame_done_o), 0);
            chk("to_error_sticky", 32'(error_o), 1);
            chk("to_idle_pred_start", 32'(pred_start_o), 0);
        end
        pred_done_i = 1'b0;

        // Restart clears the error and begins again at MB 0; reset hits MB 40.
        start_frame();
        for (int i = 0; i < 40; i++)
            do_mb($urandom_range(0, 4), $urandom_range(0, 2), 3'($urandom_range(1, 7)));
        chk("mb40_mbnumber", 32'(mbnumber_o), 40);
        chk("mb40_pred_start", 32'(pred_start_o), 1);
        #2;
        reset_i = 1'b1;
        #1;
        chk_reset("async_rst");
        tick();
        chk_reset("rst_hold");
        reset_i = 1'b0;
        tick();
        chk("post_rst_frame_done", 32'(frame_done_o), 0);
        chk("post_rst_busy", 32'(busy_o), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/intra16x16_mb_sequencer.md
# intra16x16_mb_sequencer

Frame-level controller for the Intra 16x16 luma path. It walks macroblocks in raster order and launches the prediction/SAD engine for each one. When the engine finishes, it fires the 16x16 saver's enable and captures the mode the saver selected. It sits between the frame controller (`frame_start`/`frame_done`) and the prediction engine + `saver_luma16x16` pair, and supplies their shared `mbnumber` and neighbour-availability flags.

## Interface
- `MB_COLS`, default 16: macroblocks per row (frame width / 16).
- `MB_ROWS`, default 16: macroblock rows per frame.
- `TIMEOUT`, default 1023: maximum cycles spent waiting for `pred_done` before aborting.
- `clk`  in  1  single clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `frame_start`  in  1  one-cycle request to process a frame; honoured only in IDLE.
- `pred_done`  in  1  prediction engine has valid `sads`/`vres`/`hres`/`dcres` for the current MB.
- `sink_ready`  in  1  downstream residue consumer can accept a new MB.
- `mode`  in  3  mode output of the saver; valid the cycle after `save_enable`.
- `pred_start`  out  1  one-cycle launch pulse to the prediction engine.
- `save_enable`  out  1  one-cycle enable to the saver.
- `mbnumber`  out  9  raster index of the current MB, 0..MB_COLS*MB_ROWS-1.
- `top_avail`  out  1  current MB row > 0.
- `left_avail`  out  1  current MB column > 0.
- `last_mode`  out  3  mode of the most recently completed MB.
- `mode_valid`  out  1  one-cycle pulse when `last_mode` updates.
- `busy`  out  1  high in every state except IDLE.
- `frame_done`  out  1  one-cycle pulse after the last MB completes.
- `error`  out  1  sticky timeout flag.

## Operation
- **States:** IDLE, LAUNCH, WAIT_PRED, HOLD, SAVE, CAPTURE, DONE. All outputs are registered or Moore-decoded from state; there are no combinational paths from inputs to outputs.
- **IDLE:** on `frame_start`, clear the MB counter (col=0, row=0), clear `error`, go to LAUNCH.
- **LAUNCH:** `pred_start`=1 for this cycle only; clear the timeout counter; go to WAIT_PRED.
- **WAIT_PRED:**
  - `pred_done` with `sink_ready` → SAVE.
  - `pred_done` without `sink_ready` → HOLD.
  - Otherwise increment the timeout counter. When it reaches TIMEOUT, set `error` and go to IDLE; no `frame_done` is issued.
- **HOLD:** wait for `sink_ready`, then → SAVE. HOLD has no timeout.
- **SAVE:** `save_enable`=1 for exactly one cycle; → CAPTURE.
- **CAPTURE:**
  - At the exit edge: `last_mode` ← `mode`, and `mode_valid` pulses for the following cycle.
  - Advance the counter: col+1, wrapping to 0 with row+1 at col=MB_COLS-1.
  - If the completed MB was MB_COLS*MB_ROWS-1 → DONE, else → LAUNCH.
- **DONE:** `frame_done`=1 for one cycle; → IDLE.
- **Index and availability:** `mbnumber` = row*MB_COLS + col, computed in 9 bits with no overflow for the default parameters. `top_avail` = (row≠0) and `left_avail` = (col≠0). All three are stable from LAUNCH through CAPTURE of each MB.
- **Ignored inputs:**
  - `pred_done` outside WAIT_PRED.
  - `frame_start` outside IDLE (no queuing).
  - `mode` outside CAPTURE.
- **Reset values:** state IDLE; all pulses 0; `mbnumber`=0; `top_avail`=0; `left_avail`=0; `last_mode`=0; `busy`=0; `error`=0.
- **Reset mid-frame** returns every output to its reset value immediately (asynchronous), with no `frame_done`.

## Timing
- `frame_start` sampled high at edge E → `pred_start` high during cycle E..E+1; `busy` rises at E.
- Best-case per-MB latency is 4 cycles: LAUNCH, WAIT_PRED (with `pred_done` already high), SAVE, CAPTURE.
- Each cycle `sink_ready` is low adds one HOLD cycle.
- Every extra WAIT_PRED cycle adds one cycle; a timeout fires after TIMEOUT+1 WAIT_PRED cycles.
- `save_enable` and `pred_start` never overlap.
- Only one `pred_start` is issued per MB.
- `frame_done` follows the last `mode_valid` by 1 cycle, and `busy` falls on the same edge.
- A full default frame (256 MBs, best case) takes 1 + 256*4 cycles from `frame_start` to `frame_done`.

## Test plan
- **Full frame, best case:** `pred_done`/`sink_ready` tied high → 256 `pred_start` and 256 `save_enable` pulses; `mbnumber` sequence 0..255; `frame_done` exactly 1025 cycles after `frame_start`.
- **Availability flags:** MB 0 → top=0, left=0; MB 5 → top=0, left=1; MB 16 → top=1, left=0; MB 17 → top=1, left=1.
- **Mode capture:** the saver model returns `mode`=2 for MB 3 → `last_mode`=2 with `mode_valid` pulse exactly 2 cycles after MB 3's `save_enable`.
- **Backpressure:** `sink_ready` low for 7 cycles when `pred_done` arrives → 7 HOLD cycles, then a single `save_enable`; `pred_done` pulses during HOLD do not cause a second save.
- **Timeout:** `pred_done` never asserted, TIMEOUT=15 → `error`=1 and `busy`=0 after 16 WAIT_PRED cycles, no `frame_done`; the next `frame_start` clears `error` and restarts at MB 0.
- **Disruptions:** `reset` asserted during MB 40 → all outputs to reset values immediately. A `frame_start` issued mid-frame is ignored, and `mbnumber` continues unchanged.
